rc6_key_schedule: RTL

- Sequential RC6 key-expansion engine for w=32 with a 128-bit user key.
- Sits directly upstream of the RC6 encryption datapath and produces its 2R+4 round keys S[0..2R+3].
- One user key is expanded per start, one mixing step per clock, into an internal round-key RAM.
- The encryption stage reads the round keys through a registered read port once keys_valid is high.

---
 rtl/rc6_key_schedule.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/rc6_key_schedule.sv
// RC6-32/R/b key expansion engine: INIT fills S with the P32/Q32 progression,
// MIX runs 3*max(C,T) single-cycle mixing steps over S and the user key words L.
module rc6_key_schedule #(
  parameter int unsigned R = 20,
  parameter int unsigned C = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [32*C-1:0]             key,
  output logic                        busy,
  output logic                        keys_valid,
  output logic                        done,
  input  logic [$clog2(2*R+4)-1:0]    rk_addr,
  output logic [31:0]                 rk_data
);

  localparam int unsigned W  = 32;
  localparam int unsigned T  = 2 * R + 4;
  localparam int unsigned N  = 3 * ((C > T) ? C : T);
  localparam int unsigned IW = $clog2(T);
  localparam int unsigned JW = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned NW = $clog2(N);

  localparam logic [W-1:0]  P32    = 32'hB7E15163;
  localparam logic [W-1:0]  Q32    = 32'h9E3779B9;
  localparam logic [IW-1:0] I_LAST = IW'(T - 1);
  localparam logic [JW-1:0] J_LAST = JW'(C - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N - 1);
  localparam logic [IW:0]   T_L    = (IW + 1)'(T);

  typedef enum logic [2:0] {IDLE, LOAD, INIT, MIX, READY} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic [JW-1:0]   j_q, j_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            done_q, done_d;
  logic [W-1:0]    rk_data_q, rk_data_d;

  logic [W-1:0]    s_q [T];
  logic [W-1:0]    l_q [C];

  logic            s_we;
  logic [W-1:0]    s_wdata;
  logic            l_we;
  logic            l_load;
  logic [W-1:0]    l_wdata;
  logic [W-1:0]    mix_a;
  logic [W-1:0]    mix_ab;
  logic [W-1:0]    mix_b;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [4:0] n);
    logic [2*W-1:0] t;
    t = {x, x} << n;
    return t[2*W-1:W];
  endfunction

  always_comb begin
    mix_a  = rotl(s_q[i_q] + a_q + b_q, 5'd3);
    mix_ab = mix_a + b_q;
    mix_b  = rotl(l_q[j_q] + mix_ab, mix_ab[4:0]);
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    s_we    = 1'b0;
    s_wdata = a_q;
    l_we    = 1'b0;
    l_load  = 1'b0;
    l_wdata = b_q;
    case (state_q)
      IDLE, READY: begin
        if (start) begin
          l_load  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        i_d     = '0;
        a_d     = P32;
        state_d = INIT;
      end
      // A doubles as the running P32 + k*Q32 accumulator during INIT.
      INIT: begin
        s_we    = 1'b1;
        s_wdata = a_q;
        a_d     = a_q + Q32;
        if (i_q == I_LAST) begin
          i_d     = '0;
          j_d     = '0;
          a_d     = '0;
          b_d     = '0;
          cnt_d   = '0;
          state_d = MIX;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      MIX: begin
        s_we    = 1'b1;
        s_wdata = mix_a;
        l_we    = 1'b1;
        l_wdata = mix_b;
        a_d     = mix_a;
        b_d     = mix_b;
        i_d     = (i_q == I_LAST) ? '0 : i_q + IW'(1);
        j_d     = (j_q == J_LAST) ? '0 : j_q + JW'(1);
        if (cnt_q == N_LAST) begin
          state_d = READY;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + NW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rk_data_d = '0;
    if ({1'b0, rk_addr} < T_L) rk_data_d = s_q[rk_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      done_q    <= 1'b0;
      rk_data_q <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      done_q    <= done_d;
      rk_data_q <= rk_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (s_we) s_q[i_q] <= s_wdata;
    if (l_load) begin
      for (int unsigned c = 0; c < C; c++) l_q[c] <= key[32*c +: 32];
    end else if (l_we) begin
      l_q[j_q] <= l_wdata;
    end
  end

  assign busy       = (state_q == LOAD) || (state_q == INIT) || (state_q == MIX);
  assign keys_valid = (state_q == READY);
  assign done       = done_q;
  assign rk_data    = rk_data_q;

endmodule
